// File: rtl/mem_queue.sv
// In-order memory stage: buffers load/store ops from execute and issues
// them one at a time to the data-memory port, returning load results.
module mem_queue #(
  parameter int ROBWIDTH = 6,
  parameter int DEPTH = 4,
  parameter int PTRW = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                Valid_Instruction_IN,
  input  logic                Mem_Instruction_IN,
  input  logic                MemRead1_IN,
  input  logic                MemWrite1_IN,
  input  logic [31:0]         address_IN,
  input  logic [31:0]         Dest_Value1_IN,
  input  logic [5:0]          writeRegister1_IN,
  input  logic [ROBWIDTH-1:0] ROBPointer_IN,
  input  logic                FLUSH_IN,
  output logic                Full_OUT,
  output logic                dmem_req_OUT,
  output logic                dmem_we_OUT,
  output logic [31:0]         dmem_addr_OUT,
  output logic [31:0]         dmem_wdata_OUT,
  input  logic                dmem_ack_IN,
  input  logic [31:0]         dmem_rdata_IN,
  output logic [31:0]         LS_fwd_data_COM,
  output logic [5:0]          LS_fwd_reg_COM,
  output logic                LS_fwd_data_COM_flag,
  output logic                LS_done_OUT,
  output logic [ROBWIDTH-1:0] LS_ROBPointer_OUT,
  output logic                LS_exc_OUT
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [PTRW:0] CNT_FULL = (PTRW+1)'(DEPTH);

  logic                q_we   [DEPTH];
  logic [31:0]         q_addr [DEPTH];
  logic [31:0]         q_data [DEPTH];
  logic [5:0]          q_reg  [DEPTH];
  logic [ROBWIDTH-1:0] q_rob  [DEPTH];

  logic [PTRW-1:0]     head;
  logic [PTRW-1:0]     tail;
  logic [PTRW:0]       count;
  logic [0:0]          state;
  logic                squash;
  logic [5:0]          cur_reg;
  logic [ROBWIDTH-1:0] cur_rob;

  logic enq;
  logic deq;
  logic nonempty;
  logic head_mis;
  logic issue;
  logic mis_deq;
  logic ack_done;

  assign Full_OUT = (count == CNT_FULL);
  assign nonempty = (count != '0);
  assign head_mis = (q_addr[head][1:0] != 2'b00);

  assign enq = Valid_Instruction_IN & Mem_Instruction_IN
             & (MemRead1_IN | MemWrite1_IN)
             & ~Full_OUT & ~FLUSH_IN;

  assign issue    = (state == IDLE) & nonempty & ~head_mis & ~FLUSH_IN;
  assign mis_deq  = (state == IDLE) & nonempty & head_mis & ~FLUSH_IN;
  assign ack_done = (state == BUSY) & dmem_ack_IN;
  // the in-flight op stays at head until its ack; a squashed one was
  // already cleared from the queue by the flush
  assign deq = (ack_done & ~squash & ~FLUSH_IN) | mis_deq;

  always_ff @(posedge CLK) begin
    if (enq) begin
      q_we[tail]   <= MemWrite1_IN;
      q_addr[tail] <= address_IN;
      q_data[tail] <= Dest_Value1_IN;
      q_reg[tail]  <= writeRegister1_IN;
      q_rob[tail]  <= ROBPointer_IN;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      head                 <= '0;
      tail                 <= '0;
      count                <= '0;
      state                <= IDLE;
      squash               <= 1'b0;
      cur_reg              <= '0;
      cur_rob              <= '0;
      dmem_req_OUT         <= 1'b0;
      dmem_we_OUT          <= 1'b0;
      dmem_addr_OUT        <= '0;
      dmem_wdata_OUT       <= '0;
      LS_fwd_data_COM      <= '0;
      LS_fwd_reg_COM       <= '0;
      LS_fwd_data_COM_flag <= 1'b0;
      LS_done_OUT          <= 1'b0;
      LS_ROBPointer_OUT    <= '0;
      LS_exc_OUT           <= 1'b0;
    end else begin
      LS_done_OUT          <= 1'b0;
      LS_exc_OUT           <= 1'b0;
      LS_fwd_data_COM_flag <= 1'b0;

      if (FLUSH_IN) begin
        head  <= tail;
        count <= '0;
      end else begin
        head  <= head + PTRW'(deq);
        tail  <= tail + PTRW'(enq);
        count <= count + (PTRW+1)'(enq) - (PTRW+1)'(deq);
      end

      case (state)
        IDLE: begin
          if (issue) begin
            dmem_req_OUT   <= 1'b1;
            dmem_we_OUT    <= q_we[head];
            dmem_addr_OUT  <= q_addr[head];
            dmem_wdata_OUT <= q_data[head];
            cur_reg        <= q_reg[head];
            cur_rob        <= q_rob[head];
            state          <= BUSY;
          end else if (mis_deq) begin
            LS_done_OUT       <= 1'b1;
            LS_exc_OUT        <= 1'b1;
            LS_ROBPointer_OUT <= q_rob[head];
          end
        end
        BUSY: begin
          if (ack_done) begin
            dmem_req_OUT <= 1'b0;
            squash       <= 1'b0;
            state        <= IDLE;
            if (!squash && !FLUSH_IN) begin
              LS_done_OUT       <= 1'b1;
              LS_ROBPointer_OUT <= cur_rob;
              if (!dmem_we_OUT) begin
                LS_fwd_data_COM      <= dmem_rdata_IN;
                LS_fwd_reg_COM       <= cur_reg;
                LS_fwd_data_COM_flag <= (cur_reg != 6'd0);
              end
            end
          end else if (FLUSH_IN) begin
            squash <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_queue.sv
// Directed bench for mem_queue: reset, load/store issue, fill,
// misaligned ops, flush of an in-flight op and pointer wrap.
module tb_mem_queue;

  logic        CLK;
  logic        RESET;
  logic        Valid_Instruction_IN;
  logic        Mem_Instruction_IN;
  logic        MemRead1_IN;
  logic        MemWrite1_IN;
  logic [31:0] address_IN;
  logic [31:0] Dest_Value1_IN;
  logic [5:0]  writeRegister1_IN;
  logic [5:0]  ROBPointer_IN;
  logic        FLUSH_IN;
  logic        Full_OUT;
  logic        dmem_req_OUT;
  logic        dmem_we_OUT;
  logic [31:0] dmem_addr_OUT;
  logic [31:0] dmem_wdata_OUT;
  logic        dmem_ack_IN;
  logic [31:0] dmem_rdata_IN;
  logic [31:0] LS_fwd_data_COM;
  logic [5:0]  LS_fwd_reg_COM;
  logic        LS_fwd_data_COM_flag;
  logic        LS_done_OUT;
  logic [5:0]  LS_ROBPointer_OUT;
  logic        LS_exc_OUT;

  int n_cmp = 0;
  int n_bad = 0;

  mem_queue dut (
    .CLK(CLK),
    .RESET(RESET),
    .Valid_Instruction_IN(Valid_Instruction_IN),
    .Mem_Instruction_IN(Mem_Instruction_IN),
    .MemRead1_IN(MemRead1_IN),
    .MemWrite1_IN(MemWrite1_IN),
    .address_IN(address_IN),
    .Dest_Value1_IN(Dest_Value1_IN),
    .writeRegister1_IN(writeRegister1_IN),
    .ROBPointer_IN(ROBPointer_IN),
    .FLUSH_IN(FLUSH_IN),
    .Full_OUT(Full_OUT),
    .dmem_req_OUT(dmem_req_OUT),
    .dmem_we_OUT(dmem_we_OUT),
    .dmem_addr_OUT(dmem_addr_OUT),
    .dmem_wdata_OUT(dmem_wdata_OUT),
    .dmem_ack_IN(dmem_ack_IN),
    .dmem_rdata_IN(dmem_rdata_IN),
    .LS_fwd_data_COM(LS_fwd_data_COM),
    .LS_fwd_reg_COM(LS_fwd_reg_COM),
    .LS_fwd_data_COM_flag(LS_fwd_data_COM_flag),
    .LS_done_OUT(LS_done_OUT),
    .LS_ROBPointer_OUT(LS_ROBPointer_OUT),
    .LS_exc_OUT(LS_exc_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    Valid_Instruction_IN = 1'b0;
    Mem_Instruction_IN   = 1'b0;
    MemRead1_IN          = 1'b0;
    MemWrite1_IN         = 1'b0;
    address_IN           = '0;
    Dest_Value1_IN       = '0;
    writeRegister1_IN    = '0;
    ROBPointer_IN        = '0;
  endtask

  task automatic put(input logic we, input logic [31:0] a,
                     input logic [31:0] d, input logic [5:0] r,
                     input logic [5:0] t);
    Valid_Instruction_IN = 1'b1;
    Mem_Instruction_IN   = 1'b1;
    MemRead1_IN          = ~we;
    MemWrite1_IN         = we;
    address_IN           = a;
    Dest_Value1_IN       = d;
    writeRegister1_IN    = r;
    ROBPointer_IN        = t;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    FLUSH_IN = 1'b0;
    dmem_ack_IN = 1'b0;
    dmem_rdata_IN = '0;
    idle_in();
    #2;
    n_cmp++; if (dmem_req_OUT !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", dmem_req_OUT); end
    n_cmp++; if (Full_OUT !== 1'b0) begin n_bad++; $display("FAIL rst_full got %b want 0", Full_OUT); end
    n_cmp++; if (LS_done_OUT !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", LS_done_OUT); end
    n_cmp++; if (LS_fwd_data_COM !== 32'h0) begin n_bad++; $display("FAIL rst_data got %h want 0", LS_fwd_data_COM); end
    step();
    RESET = 1'b1;
    step();
  endtask

  task automatic test_reset_busy();
    put(1'b0, 32'h100, 32'h0, 6'd4, 6'd2);
    step();
    idle_in();
    step();
    n_cmp++; if (dmem_req_OUT !== 1'b1) begin n_bad++; $display("FAIL rb_req_pre got %b want 1", dmem_req_OUT); end
    RESET = 1'b0;
    #1;
    n_cmp++; if (dmem_req_OUT !== 1'b0) begin n_bad++; $display("FAIL rb_req got %b want 0", dmem_req_OUT); end
    n_cmp++; if (dmem_addr_OUT !== 32'h0) begin n_bad++; $display("FAIL rb_addr got %h want 0", dmem_addr_OUT); end
    n_cmp++; if (Full_OUT !== 1'b0) begin n_bad++; $display("FAIL rb_full got %b want 0", Full_OUT); end
    step();
    RESET = 1'b1;
    step();
    n_cmp++; if (dmem_req_OUT !== 1'b0) begin n_bad++; $display("FAIL rb_req_post got %b want 0", dmem_req_OUT); end
  endtask

  task automatic test_single_load();
    put(1'b0, 32'h100, 32'h0, 6'd5, 6'd3);
    step();
    idle_in();
    n_cmp++; if (dmem_req_OUT !== 1'b0) begin n_bad++; $display("FAIL sl_req_early got %b want 0", dmem_req_OUT); end
    step();
    n_cmp++; if (dmem_req_OUT !== 1'b1) begin n_bad++; $display("FAIL sl_req got %b want 1", dmem_req_OUT); end
    n_cmp++; if (dmem_we_OUT !== 1'b0) begin n_bad++; $display("FAIL sl_we got %b want 0", dmem_we_OUT); end
    n_cmp++; if (dmem_addr_OUT !== 32'h100) begin n_bad++; $display("FAIL sl_addr got %h want 100", dmem_addr_OUT); end
    dmem_ack_IN = 1'b1;
    dmem_rdata_IN = 32'hDEADBEEF;
    step();
    dmem_ack_IN = 1'b0;
    n_cmp++; if (LS_fwd_data_COM_flag !== 1'b1) begin n_bad++; $display("FAIL sl_flag got %b want 1", LS_fwd_data_COM_flag); end
    n_cmp++; if (LS_fwd_data_COM !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sl_data got %h want deadbeef", LS_fwd_data_COM); end
    n_cmp++; if (LS_fwd_reg_COM !== 6'd5) begin n_bad++; $display("FAIL sl_reg got %0d want 5", LS_fwd_reg_COM); end
    n_cmp++; if (LS_done_OUT !== 1'b1) begin n_bad++; $display("FAIL sl_done got %b want 1", LS_done_OUT); end
    n_cmp++; if (LS_ROBPointer_OUT !== 6'd3) begin n_bad++; $display("FAIL sl_rob got %0d want 3", LS_ROBPointer_OUT); end
    n_cmp++; if (LS_exc_OUT !== 1'b0) begin n_bad++; $display("FAIL sl_exc got %b want 0", LS_exc_OUT); end
    step();
    n_cmp++; if (LS_fwd_data_COM_flag !== 1'b0) begin n_bad++; $display("FAIL sl_flag_fall got %b want 0", LS_fwd_data_COM_flag); end
    n_cmp++; if (LS_done_OUT !== 1'b0) begin n_bad++; $display("FAIL sl_done_fall got %b want 0", LS_done_OUT); end
    n_cmp++; if (LS_fwd_data_COM !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sl_data_hold got %h want deadbeef", LS_fwd_data_COM); end
    n_cmp++; if (dmem_req_OUT !== 1'b0) begin n_bad++; $display("FAIL sl_req_fall got %b want 0", dmem_req_OUT); end
  endtask

  task automatic test_fill();
    logic [31:0] ea;
    for (int i = 0; i < 4; i++) begin
      put(1'b1, 32'(i * 4), 32'hA0 + 32'(i), 6'd0, 6'(10 + i));
      step();
    end
    n_cmp++; if (Full_OUT !== 1'b1) begin n_bad++; $display("FAIL fill_full got %b want 1", Full_OUT); end
    put(1'b1, 32'h10, 32'hA4, 6'd0, 6'd14);
    for (int h = 0; h < 3; h++) begin
      step();
      n_cmp++; if (Full_OUT !== 1'b1) begin n_bad++; $display("FAIL fill_hold%0d got %b want 1", h, Full_OUT); end
    end
    for (int k = 0; k < 5; k++) begin
      ea = 32'(k * 4);
      n_cmp++; if (dmem_req_OUT !== 1'b1) begin n_bad++; $display("FAIL fill_req%0d got %b want 1", k, dmem_req_OUT); end
      n_cmp++; if (dmem_we_OUT !== 1'b1) begin n_bad++; $display("FAIL fill_we%0d got %b want 1", k, dmem_we_OUT); end
      n_cmp++; if (dmem_addr_OUT !== ea) begin n_bad++; $display("FAIL fill_addr%0d got %h want %h", k, dmem_addr_OUT, ea); end
      n_cmp++; if (dmem_wdata_OUT !== 32'hA0 + 32'(k)) begin n_bad++; $display("FAIL fill_wdata%0d got %h want %h", k, dmem_wdata_OUT, 32'hA0 + 32'(k)); end
      dmem_ack_IN = 1'b1;
      step();
      dmem_ack_IN = 1'b0;
      n_cmp++; if (LS_done_OUT !== 1'b1) begin n_bad++; $display("FAIL fill_done%0d got %b want 1", k, LS_done_OUT); end
      n_cmp++; if (LS_ROBPointer_OUT !== 6'(10 + k)) begin n_bad++; $display("FAIL fill_rob%0d got %0d want %0d", k, LS_ROBPointer_OUT, 10 + k); end
      n_cmp++; if (LS_fwd_data_COM_flag !== 1'b0) begin n_bad++; $display("FAIL fill_flag%0d got %b want 0", k, LS_fwd_data_COM_flag); end
      step();
      if (k == 0) idle_in();
    end
    n_cmp++; if (dmem_req_OUT !== 1'b0) begin n_bad++; $display("FAIL fill_drain got %b want 0", dmem_req_OUT); end
  endtask

  task automatic test_misaligned();
    put(1'b0, 32'h102, 32'h0, 6'd7, 6'd20);
    step();
    idle_in();
    n_cmp++; if (LS_done_OUT !== 1'b0) begin n_bad++; $display("FAIL mis_done_early got %b want 0", LS_done_OUT); end
    step();
    n_cmp++; if (dmem_req_OUT !== 1'b0) begin n_bad++; $display("FAIL mis_req got %b want 0", dmem_req_OUT); end
    n_cmp++; if (LS_done_OUT !== 1'b1) begin n_bad++; $display("FAIL mis_done got %b want 1", LS_done_OUT); end
    n_cmp++; if (LS_exc_OUT !== 1'b1) begin n_bad++; $display("FAIL mis_exc got %b want 1", LS_exc_OUT); end
    n_cmp++; if (LS_ROBPointer_OUT !== 6'd20) begin n_bad++; $display("FAIL mis_rob got %0d want 20", LS_ROBPointer_OUT); end
    n_cmp++; if (LS_fwd_data_COM_flag !== 1'b0) begin n_bad++; $display("FAIL mis_flag got %b want 0", LS_fwd_data_COM_flag); end
    step();
    n_cmp++; if (LS_exc_OUT !== 1'b0) begin n_bad++; $display("FAIL mis_exc_fall got %b want 0", LS_exc_OUT); end
    n_cmp++; if (dmem_req_OUT !== 1'b0) begin n_bad++; $display("FAIL mis_req_after got %b want 0", dmem_req_OUT); end
  endtask

  task automatic test_flush();
    put(1'b0, 32'h200, 32'h0, 6'd8, 6'd30);
    step();
    put(1'b0, 32'h204, 32'h0, 6'd9, 6'd31);
    step();
    put(1'b0, 32'h208, 32'h0, 6'd10, 6'd32);
    step();
    idle_in();
    n_cmp++; if (dmem_addr_OUT !== 32'h200) begin n_bad++; $display("FAIL fl_addr got %h want 200", dmem_addr_OUT); end
    FLUSH_IN = 1'b1;
    step();
    FLUSH_IN = 1'b0;
    n_cmp++; if (dmem_req_OUT !== 1'b1) begin n_bad++; $display("FAIL fl_req_hold got %b want 1", dmem_req_OUT); end
    for (int w = 0; w < 2; w++) begin
      step();
      n_cmp++; if (LS_done_OUT !== 1'b0) begin n_bad++; $display("FAIL fl_wait%0d got %b want 0", w, LS_done_OUT); end
    end
    dmem_ack_IN = 1'b1;
    dmem_rdata_IN = 32'hCAFE0000;
    step();
    dmem_ack_IN = 1'b0;
    n_cmp++; if (LS_done_OUT !== 1'b0) begin n_bad++; $display("FAIL fl_done got %b want 0", LS_done_OUT); end
    n_cmp++; if (LS_fwd_data_COM_flag !== 1'b0) begin n_bad++; $display("FAIL fl_flag got %b want 0", LS_fwd_data_COM_flag); end
    n_cmp++; if (dmem_req_OUT !== 1'b0) begin n_bad++; $display("FAIL fl_req_fall got %b want 0", dmem_req_OUT); end
    step();
    step();
    n_cmp++; if (dmem_req_OUT !== 1'b0) begin n_bad++; $display("FAIL fl_empty got %b want 0", dmem_req_OUT); end
    put(1'b0, 32'h300, 32'h0, 6'd11, 6'd33);
    step();
    idle_in();
    step();
    n_cmp++; if (dmem_addr_OUT !== 32'h300) begin n_bad++; $display("FAIL fl_next_addr got %h want 300", dmem_addr_OUT); end
    dmem_ack_IN = 1'b1;
    dmem_rdata_IN = 32'h12345678;
    step();
    dmem_ack_IN = 1'b0;
    n_cmp++; if (LS_done_OUT !== 1'b1) begin n_bad++; $display("FAIL fl_next_done got %b want 1", LS_done_OUT); end
    n_cmp++; if (LS_ROBPointer_OUT !== 6'd33) begin n_bad++; $display("FAIL fl_next_rob got %0d want 33", LS_ROBPointer_OUT); end
    n_cmp++; if (LS_fwd_data_COM !== 32'h12345678) begin n_bad++; $display("FAIL fl_next_data got %h want 12345678", LS_fwd_data_COM); end
    step();
  endtask

  task automatic test_wrap();
    logic [31:0] ea;
    for (int i = 0; i < 10; i++) begin
      ea = 32'h400 + 32'(i * 4);
      put(1'b0, ea, 32'h0, 6'(i), 6'(40 + i));
      step();
      idle_in();
      step();
      n_cmp++; if (dmem_addr_OUT !== ea) begin n_bad++; $display("FAIL wr_addr%0d got %h want %h", i, dmem_addr_OUT, ea); end
      dmem_ack_IN = 1'b1;
      dmem_rdata_IN = 32'h5000 + 32'(i);
      step();
      dmem_ack_IN = 1'b0;
      n_cmp++; if (LS_done_OUT !== 1'b1) begin n_bad++; $display("FAIL wr_done%0d got %b want 1", i, LS_done_OUT); end
      n_cmp++; if (LS_ROBPointer_OUT !== 6'(40 + i)) begin n_bad++; $display("FAIL wr_rob%0d got %0d want %0d", i, LS_ROBPointer_OUT, 40 + i); end
      n_cmp++; if (LS_fwd_reg_COM !== 6'(i)) begin n_bad++; $display("FAIL wr_reg%0d got %0d want %0d", i, LS_fwd_reg_COM, i); end
      n_cmp++; if (LS_fwd_data_COM !== 32'h5000 + 32'(i)) begin n_bad++; $display("FAIL wr_data%0d got %h want %h", i, LS_fwd_data_COM, 32'h5000 + 32'(i)); end
      n_cmp++; if (LS_fwd_data_COM_flag !== (i != 0)) begin n_bad++; $display("FAIL wr_flag%0d got %b want %b", i, LS_fwd_data_COM_flag, (i != 0)); end
    end
    step();
    n_cmp++; if (dmem_req_OUT !== 1'b0) begin n_bad++; $display("FAIL wr_dup got %b want 0", dmem_req_OUT); end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_fill();
    test_misaligned();
    test_flush();
    test_wrap();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
